// File: rtl/alu_engine_pkg.sv
// alu_engine_pkg: opcodes, register map, status bit positions and sequencer states
package alu_engine_pkg;
   localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                          OP_OR  = 4'd4, OP_XOR = 4'd5, OP_NOT = 4'd6, OP_SHL = 4'd7,
                          OP_SHR = 4'd8, OP_ASR = 4'd9, OP_MUL = 4'd10, OP_SLT = 4'd11;
   localparam int REG_CTRL = 'h00, REG_STATUS = 'h01, REG_INT_CLR = 'h02, REG_INST = 'h03,
                  REG_RESULT = 'h04, REG_OPND = 'h10;
   localparam int CTRL_START = 0, CTRL_IRQ_EN = 1, CTRL_CLR = 2;
   localparam int ST_BUSY = 0, ST_INST_FULL = 1, ST_INST_EMPTY = 2, ST_RES_FULL = 3,
                  ST_RES_EMPTY = 4, ST_DONE = 5, ST_ERR = 6;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_PUSH, S_PUSH_HI, S_FIN} state_t;
endpackage

// File: rtl/alu_sync_fifo.sv
// alu_sync_fifo: show-ahead synchronous FIFO with flush; a write to a full FIFO is accepted when a read pops in the same cycle
module alu_sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clr,
   input  logic                     wr,
   input  logic [W-1:0]             din,
   input  logic                     rd,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_wr, do_rd;

   assign do_rd = rd & !empty;
   assign do_wr = wr & (!full | do_rd);
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign dout  = mem[rp];

   // Storage array, written at the tail
   always_ff @(posedge clk)
      if (do_wr) mem[wp] <= din;

   // Pointers and occupancy; flush empties the FIFO at once
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else if (clr) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         wp <= wp + AW'(do_wr);
         rp <= rp + AW'(do_rd);
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
endmodule

// File: rtl/alu_engine_param.sv
// alu_engine_param: memory-mapped ALU accelerator with operand file, instruction/result FIFOs and execute sequencer
module alu_engine_param
   import alu_engine_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16,
   parameter int OPND_DEPTH = 16,
   parameter int INST_DEPTH = 8,
   parameter int RES_DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_sel,
   input  logic              s_wr,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_din,
   output logic [DATA_W-1:0] s_dout,
   output logic              s_interrupt
);
   localparam int OW = $clog2(OPND_DEPTH);
   localparam int IW = $clog2(INST_DEPTH) + 1;
   localparam int RW = $clog2(RES_DEPTH) + 1;

   state_t state;
   logic start, irq_en, done, err;
   logic [DATA_W-1:0] opnd [OPND_DEPTH];
   logic [31:0] ir;
   logic [3:0] op;
   logic [DATA_W-1:0] a_q, b_q, res_lo, res_hi, inst_head, res_head, res_din, rd_data, alu_lo, asr;
   logic [2*DATA_W-1:0] alu;
   logic [4:0] sh;
   logic [IW-1:0] inst_cnt;
   logic [RW-1:0] res_cnt;
   logic inst_full, inst_empty, res_full, res_empty, inst_wr, inst_rd, res_wr, res_rd;
   logic bus_wr, bus_rd, ctrl_w, int_clr_w, inst_w, clr, opnd_hit, busy, bad, done_set, err_set;
   logic [ADDR_W-1:0] opnd_off;
   logic [15:0] status;
   logic unused_ok;

   assign bus_wr    = s_sel & s_wr;
   assign bus_rd    = s_sel & !s_wr;
   assign ctrl_w    = bus_wr && s_addr == ADDR_W'(REG_CTRL);
   assign int_clr_w = bus_wr && s_addr == ADDR_W'(REG_INT_CLR);
   assign inst_w    = bus_wr && s_addr == ADDR_W'(REG_INST);
   assign clr       = ctrl_w & s_din[CTRL_CLR];
   assign opnd_off  = s_addr - ADDR_W'(REG_OPND);
   assign opnd_hit  = s_addr >= ADDR_W'(REG_OPND) && opnd_off < ADDR_W'(OPND_DEPTH);
   assign busy      = state != S_IDLE;
   assign op        = ir[31:28];
   assign sh        = b_q[4:0];
   assign bad       = op > OP_SLT || int'(ir[15:8]) >= OPND_DEPTH || int'(ir[7:0]) >= OPND_DEPTH;
   assign inst_wr   = inst_w & !inst_full;
   assign inst_rd   = state == S_FETCH && !inst_empty;
   assign res_rd    = bus_rd && s_addr == ADDR_W'(REG_RESULT);
   assign res_wr    = (state == S_PUSH || state == S_PUSH_HI) && (!res_full || res_rd);
   assign res_din   = state == S_PUSH_HI ? res_hi : res_lo;
   assign done_set  = state == S_FIN;
   assign err_set   = (state == S_DECODE && bad) || (inst_w && inst_full) || (bus_wr && opnd_hit && busy);
   assign asr       = $signed(a_q) >>> sh;
   assign s_interrupt = irq_en & (done | err);
   assign unused_ok = ^{ir[27:16], inst_cnt};

   alu_sync_fifo #(.W(DATA_W), .DEPTH(INST_DEPTH)) u_inst (
      .clk(clk), .reset_n(reset_n), .clr(clr), .wr(inst_wr), .din(s_din), .rd(inst_rd),
      .dout(inst_head), .full(inst_full), .empty(inst_empty), .count(inst_cnt));

   alu_sync_fifo #(.W(DATA_W), .DEPTH(RES_DEPTH)) u_res (
      .clk(clk), .reset_n(reset_n), .clr(clr), .wr(res_wr), .din(res_din), .rd(res_rd),
      .dout(res_head), .full(res_full), .empty(res_empty), .count(res_cnt));

   // ALU: single-width result for all ops, full product for MUL
   always_comb begin
      alu_lo = op == OP_ADD ? a_q + b_q :
               op == OP_SUB ? a_q - b_q :
               op == OP_AND ? a_q & b_q :
               op == OP_OR  ? a_q | b_q :
               op == OP_XOR ? a_q ^ b_q :
               op == OP_NOT ? ~a_q :
               op == OP_SHL ? a_q << sh :
               op == OP_SHR ? a_q >> sh :
               op == OP_ASR ? asr :
               op == OP_SLT ? DATA_W'($signed(a_q) < $signed(b_q)) : '0;
      alu = op == OP_MUL ? {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q} : {{DATA_W{1'b0}}, alu_lo};
   end

   // STATUS register image
   always_comb begin
      status = '0;
      status[ST_BUSY] = busy;
      status[ST_INST_FULL] = inst_full;
      status[ST_INST_EMPTY] = inst_empty;
      status[ST_RES_FULL] = res_full;
      status[ST_RES_EMPTY] = res_empty;
      status[ST_DONE] = done;
      status[ST_ERR] = err;
      status[15:8] = 8'(res_cnt);
   end

   // Bus read mux; an empty RESULT pop reads as zero
   always_comb
      rd_data = s_addr == ADDR_W'(REG_CTRL)   ? DATA_W'({irq_en, start}) :
                s_addr == ADDR_W'(REG_STATUS) ? DATA_W'(status) :
                s_addr == ADDR_W'(REG_RESULT) ? (res_empty ? '0 : res_head) :
                opnd_hit ? opnd[opnd_off[OW-1:0]] : '0;

   // Registered read data, held until the next read
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) s_dout <= '0;
      else if (bus_rd) s_dout <= rd_data;

   // Operand file: host writes only while the sequencer is idle
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) for (int i = 0; i < OPND_DEPTH; i++) opnd[i] <= '0;
      else if (bus_wr && opnd_hit && !busy) opnd[opnd_off[OW-1:0]] <= s_din;

   // Control and sticky status; CLR beats START, event set beats INT_CLR
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         start <= 1'b0;
         irq_en <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         start <= clr || done_set ? 1'b0 : ctrl_w && !busy ? s_din[CTRL_START] : start;
         irq_en <= ctrl_w ? s_din[CTRL_IRQ_EN] : irq_en;
         done <= done_set | (done & !(int_clr_w & s_din[0]));
         err <= err_set | (err & !(int_clr_w & s_din[1]));
      end

   // Execute sequencer: fetch, validate, execute, push one or two results
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= S_IDLE;
         ir <= '0;
         a_q <= '0;
         b_q <= '0;
         res_lo <= '0;
         res_hi <= '0;
      end else if (clr) state <= S_IDLE;
      else case (state)
         S_IDLE:    if (start) state <= S_FETCH;
         S_FETCH:   if (inst_empty) state <= S_FIN;
                    else begin
                       ir <= inst_head[31:0];
                       state <= S_DECODE;
                    end
         S_DECODE:  if (bad) state <= S_FETCH;
                    else begin
                       a_q <= opnd[ir[8 +: OW]];
                       b_q <= opnd[ir[0 +: OW]];
                       state <= S_EXEC;
                    end
         S_EXEC:    begin
                       {res_hi, res_lo} <= alu;
                       state <= op == OP_NOP ? S_FETCH : S_PUSH;
                    end
         S_PUSH:    if (res_wr) state <= op == OP_MUL ? S_PUSH_HI : S_FETCH;
         S_PUSH_HI: if (res_wr) state <= S_FETCH;
         S_FIN:     state <= S_IDLE;
         default:   state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_alu_engine_param.sv
// tb_alu_engine_param: scoreboard bench with a behavioural ALU model and randomized instruction streams
module tb_alu_engine_param;
   logic clk = 1'b0, reset_n = 1'b0, s_sel = 1'b0, s_wr = 1'b0, s_interrupt;
   logic [15:0] s_addr = '0;
   logic [31:0] s_din = '0, s_dout;
   logic rd_res_q = 1'b0;
   int checks = 0, errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] opnd_m [16];

   alu_engine_param dut (
      .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
      .s_din(s_din), .s_dout(s_dout), .s_interrupt(s_interrupt));

   always #5 clk = ~clk;

   always @(posedge clk) rd_res_q <= s_sel && !s_wr && s_addr == 16'h0004;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every RESULT pop is compared with the oldest expected value (zero when none is owed)
   always @(negedge clk)
      if (rd_res_q) begin
         logic [31:0] e;
         e = exp_q.size() != 0 ? exp_q.pop_front() : 32'h0;
         chk("result", s_dout, e);
      end

   task automatic wr(input int a, input logic [31:0] d);
      @(negedge clk);
      s_sel = 1'b1; s_wr = 1'b1; s_addr = 16'(a); s_din = d;
      @(negedge clk);
      s_sel = 1'b0; s_wr = 1'b0;
   endtask

   task automatic rd(input int a, output logic [31:0] d);
      @(negedge clk);
      s_sel = 1'b1; s_wr = 1'b0; s_addr = 16'(a);
      @(negedge clk);
      s_sel = 1'b0;
      d = s_dout;
   endtask

   task automatic pop();
      logic [31:0] d;
      rd(4, d);
   endtask

   task automatic wopnd(input int i, input logic [31:0] d);
      wr(16 + i, d);
      opnd_m[i] = d;
   endtask

   // Reference: what the instruction should leave in the result stream
   task automatic push_inst(input logic [31:0] ins);
      int op, ia, ib;
      logic [31:0] a, b, pw;
      longint unsigned p;
      wr(3, ins);
      op = int'(ins[31:28]); ia = int'(ins[15:8]); ib = int'(ins[7:0]);
      if (op > 11 || ia > 15 || ib > 15 || op == 0) return;
      a = opnd_m[ia]; b = opnd_m[ib];
      pw = 32'd1 << (b % 32);
      case (op)
         1: exp_q.push_back(a + b);
         2: exp_q.push_back(a - b);
         3: exp_q.push_back(a & b);
         4: exp_q.push_back(a | b);
         5: exp_q.push_back(a ^ b);
         6: exp_q.push_back(~a);
         7: exp_q.push_back(a * pw);
         8: exp_q.push_back(a / pw);
         9: exp_q.push_back(a[31] ? ~((~a) / pw) : a / pw);
         10: begin
            p = longint'(a) * longint'(b);
            exp_q.push_back(p[31:0]);
            exp_q.push_back(p[63:32]);
         end
         default: exp_q.push_back($signed(a) < $signed(b) ? 32'd1 : 32'd0);
      endcase
   endtask

   task automatic chk_status(input string nm, input logic [31:0] mask, input logic [31:0] val);
      logic [31:0] st;
      rd(1, st);
      chk(nm, st & mask, val);
   endtask

   task automatic wait_done();
      logic [31:0] st;
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         rd(1, st);
         ok = st[5];
      end
      chk("done_wait", {31'b0, ok}, 32'd1);
   endtask

   task automatic push_when_room(input logic [31:0] ins);
      logic [31:0] st;
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         rd(1, st);
         ok = !st[1];
      end
      chk("inst_room", {31'b0, ok}, 32'd1);
      push_inst(ins);
   endtask

   // 17 ADDs into a 16-deep result FIFO with no pops: ends stalled
   task automatic fill_stall();
      wopnd(0, 10); wopnd(1, 20); wopnd(2, 30); wopnd(3, 40);
      for (int i = 0; i < 17; i++) begin
         if (i == 8) wr(0, 1);
         if (i < 8) push_inst(32'h1000_0000 | 32'((i % 4) << 8) | 32'((i + 1) % 4));
         else push_when_room(32'h1000_0000 | 32'((i % 4) << 8) | 32'((i + 1) % 4));
      end
      repeat (150) @(negedge clk);
   endtask

   initial begin
      logic [31:0] v, st, ins;
      int n, nres, op, ia, ib;
      bit bad_any;
      for (int i = 0; i < 16; i++) opnd_m[i] = '0;
      repeat (3) @(negedge clk);
      chk("reset_dout", s_dout, 32'h0);
      chk("reset_irq", {31'b0, s_interrupt}, 32'h0);
      reset_n = 1'b1;
      chk_status("reset_status", 32'hFFFF_FFFF, 32'h0000_0014);
      rd(0, v);
      chk("reset_ctrl", v, 32'h0);

      // ADD/SUB, DONE and IRQ gating
      wopnd(0, 7); wopnd(1, 5);
      rd(17, v);
      chk("opnd_rb", v, 32'd5);
      push_inst(32'h1000_0001);
      push_inst(32'h2000_0001);
      wr(0, 1);
      wait_done();
      chk("irq_off", {31'b0, s_interrupt}, 32'h0);
      chk_status("status_done", 32'hFFFF, 32'h0224);
      pop(); pop();
      wr(0, 2);
      chk("irq_on", {31'b0, s_interrupt}, 32'h1);
      wr(2, 1);
      chk("irq_cleared", {31'b0, s_interrupt}, 32'h0);
      wr(0, 0);

      // MUL low then high
      wr(2, 3);
      wopnd(0, 32'hFFFF_FFFF); wopnd(1, 2);
      push_inst(32'hA000_0001);
      wr(0, 1);
      wait_done();
      pop(); pop();

      // Result back-pressure
      wr(2, 3);
      fill_stall();
      chk_status("stall", 32'hFF19, 32'h1009);
      pop();
      wait_done();
      chk_status("stall_after_pop", 32'hFF00, 32'h1000);
      repeat (16) pop();

      // Instruction FIFO overflow
      wr(2, 3);
      for (int i = 0; i < 8; i++) push_inst(32'h5000_0102);
      wr(3, 32'h5000_0102);
      chk_status("inst_ovf", 32'h42, 32'h42);
      wr(0, 1);
      wait_done();
      repeat (8) pop();

      // Illegal opcode and out-of-range index
      wr(2, 3);
      push_inst(32'hD000_0001);
      push_inst(32'h1000_1400);
      wr(0, 1);
      wait_done();
      chk_status("bad_inst", 32'hFF40, 32'h0040);
      pop();

      // CLR during a stalled run, with an operand write attempted while busy
      wr(2, 3);
      fill_stall();
      wr(16, 99);
      chk_status("opnd_busy_err", 32'h41, 32'h41);
      rd(16, v);
      chk("opnd_kept", v, 32'd10);
      wr(0, 4);
      exp_q.delete();
      chk_status("clr", 32'hFFFF, 32'h0054);
      rd(0, v);
      chk("clr_ctrl", v, 32'h0);

      // CLR wins over START in the same write
      wr(2, 3);
      wr(3, 32'h1000_0001);
      wr(0, 5);
      repeat (3) @(negedge clk);
      chk_status("clr_prio", 32'h1F, 32'h14);
      rd(0, v);
      chk("clr_prio_ctrl", v, 32'h0);

      // ASR, SLT, and an empty RESULT read
      wopnd(4, 32'h8000_0000); wopnd(5, 4); wopnd(6, 32'hFFFF_FFFF); wopnd(7, 1);
      push_inst(32'h9000_0405);
      push_inst(32'hB000_0607);
      wr(0, 1);
      wait_done();
      pop(); pop(); pop();

      // Randomized instruction streams
      for (int it = 0; it < 20; it++) begin
         bad_any = 1'b0;
         wr(2, 3);
         for (int i = 0; i < 16; i++) wopnd(i, $urandom);
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 12);
            ia = $urandom_range(0, 17);
            ib = $urandom_range(0, 17);
            if (op > 11 || ia > 15 || ib > 15) bad_any = 1'b1;
            ins = {4'(op), 12'($urandom), 8'(ia), 8'(ib)};
            push_inst(ins);
         end
         wr(0, 1);
         wait_done();
         rd(1, st);
         chk("rand_count", {24'b0, st[15:8]}, 32'(exp_q.size()));
         chk("rand_err", {31'b0, st[6]}, {31'b0, bad_any});
         nres = exp_q.size();
         repeat (nres) pop();
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
